// File: rtl/jk_counter_bank.sv
// WIDTH-bit bank of JK cells with JK / up / down / load modes, terminal count and sticky wrap flag.
// Optional build macro JK_COUNTER_SAT_EN: count modes saturate instead of wrapping.

module jk_cell (
  input  logic CLK,
  input  logic R,
  input  logic S,
  input  logic pset,
  input  logic CE,
  input  logic ld,
  input  logic d,
  input  logic j,
  input  logic k,
  output logic q
);
  always_ff @(posedge CLK) begin
    if (R)       q <= 1'b0;
    else if (S)  q <= pset;
    else if (CE) begin
      if (ld) q <= d;
      else begin
        case ({j, k})
          2'b01:   q <= 1'b0;
          2'b10:   q <= 1'b1;
          2'b11:   q <= ~q;
          default: q <= q;
        endcase
      end
    end
  end
endmodule

module jk_counter_bank #(
  parameter int               WIDTH  = 4,
  parameter logic [WIDTH-1:0] PRESET = {WIDTH{1'b1}}
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             S,
  input  logic             CE,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             OVF
);
  localparam logic [1:0] M_JK = 2'b00, M_UP = 2'b01, M_DN = 2'b10, M_LD = 2'b11;

  // upc[i]: Q[i-1:0] all ones; dnc[i]: Q[i-1:0] all zeros
  logic [WIDTH:0]   upc, dnc;
  logic [WIDTH-1:0] jv, kv;
  logic             ld;

  assign upc[0] = 1'b1;
  assign dnc[0] = 1'b1;
  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    assign upc[i+1] = upc[i] & Q[i];
    assign dnc[i+1] = dnc[i] & ~Q[i];
  end

  assign TC = CE & (((MODE == M_UP) & upc[WIDTH]) | ((MODE == M_DN) & dnc[WIDTH]));
  assign ld = (MODE == M_LD);

  always_comb begin
    jv = J;
    kv = K;
    case (MODE)
      M_UP:    begin jv = upc[WIDTH-1:0]; kv = upc[WIDTH-1:0]; end
      M_DN:    begin jv = dnc[WIDTH-1:0]; kv = dnc[WIDTH-1:0]; end
      M_LD:    begin jv = '0;             kv = '0;             end
      default: ;
    endcase
`ifdef JK_COUNTER_SAT_EN
    // the would-be wrap edge becomes a hold
    if (TC) begin
      jv = '0;
      kv = '0;
    end
`endif
  end

  jk_cell u_cell [WIDTH-1:0] (
    .CLK  (CLK),
    .R    (R),
    .S    (S),
    .pset (PRESET),
    .CE   (CE),
    .ld   (ld),
    .d    (D),
    .j    (jv),
    .k    (kv),
    .q    (Q)
  );

  // TC=1 marks the wrapping (or blocked) edge in both builds
  always_ff @(posedge CLK) begin
    if (R | S)   OVF <= 1'b0;
    else if (TC) OVF <= 1'b1;
  end
endmodule

// File: tb/tb_jk_counter_bank.sv
// Directed-vector bench for jk_counter_bank; driver pushes expectations, negedge monitor compares.
module tb_jk_counter_bank;
  logic       CLK = 1'b0;
  logic       R, S, CE;
  logic [1:0] MODE;
  logic [3:0] J, K, D, Q;
  logic       TC, OVF;

  typedef struct {
    int         id;
    logic [3:0] q;
    logic       tc;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   step_id = 0;

  jk_counter_bank #(.WIDTH(4)) dut (
    .CLK(CLK), .R(R), .S(S), .CE(CE), .MODE(MODE),
    .J(J), .K(K), .D(D), .Q(Q), .TC(TC), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  // Monitor: outputs settle after posedge; sample on negedge while inputs are held.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      if (Q !== e.q) begin
        n_bad++;
        $display("FAIL step%0d Q: got %b expected %b", e.id, Q, e.q);
      end
      n_cmp++;
      if (TC !== e.tc) begin
        n_bad++;
        $display("FAIL step%0d TC: got %b expected %b", e.id, TC, e.tc);
      end
      n_cmp++;
      if (OVF !== e.ovf) begin
        n_bad++;
        $display("FAIL step%0d OVF: got %b expected %b", e.id, OVF, e.ovf);
      end
    end
  end

  // One edge with the given inputs; expected values are those seen after the edge.
  task automatic step(input logic r, input logic s, input logic ce, input logic [1:0] m,
                      input logic [3:0] j, input logic [3:0] k, input logic [3:0] d,
                      input logic [3:0] eq, input logic etc, input logic eovf);
    exp_t e;
    R = r; S = s; CE = ce; MODE = m; J = j; K = k; D = d;
    @(posedge CLK);
    step_id++;
    e.id = step_id; e.q = eq; e.tc = etc; e.ovf = eovf;
    exp_q.push_back(e);
    @(negedge CLK);
    #1;
  endtask

  initial begin
    R = 1'b1; S = 1'b0; CE = 1'b0; MODE = 2'b00; J = '0; K = '0; D = '0;
    @(negedge CLK); #1;
    // reset state
    step(1,0,0,2'b00, 4'h0,4'h0,4'h0, 4'b0000,0,0);
    // count down from 0: wraps (or saturates), OVF set
`ifdef JK_COUNTER_SAT_EN
    step(0,0,1,2'b10, 4'h0,4'h0,4'h0, 4'b0000,1,1);
`else
    step(0,0,1,2'b10, 4'h0,4'h0,4'h0, 4'b1111,0,1);
`endif
    step(0,0,1,2'b11, 4'h0,4'h0,4'b0101, 4'b0101,0,1);
    // R with Q=0101, OVF=1; then S to PRESET
    step(1,0,1,2'b11, 4'h0,4'h0,4'b0101, 4'b0000,0,0);
    step(0,1,1,2'b11, 4'h0,4'h0,4'b0101, 4'b1111,0,0);
    // JK per-bit: hold, reset, set, toggle
    step(0,0,1,2'b11, 4'h0,4'h0,4'b1010, 4'b1010,0,0);
    step(0,0,1,2'b00, 4'b0011,4'b0101,4'h0, 4'b1011,0,0);
    // up count through terminal count
    step(0,0,1,2'b11, 4'h0,4'h0,4'b1110, 4'b1110,0,0);
    step(0,0,1,2'b01, 4'h0,4'h0,4'h0, 4'b1111,1,0);
`ifdef JK_COUNTER_SAT_EN
    step(0,0,1,2'b01, 4'h0,4'h0,4'h0, 4'b1111,1,1);
`else
    step(0,0,1,2'b01, 4'h0,4'h0,4'h0, 4'b0000,0,1);
`endif
    // down count through terminal count
    step(1,0,0,2'b00, 4'h0,4'h0,4'h0, 4'b0000,0,0);
    step(0,0,1,2'b11, 4'h0,4'h0,4'b0001, 4'b0001,0,0);
    step(0,0,1,2'b10, 4'h0,4'h0,4'h0, 4'b0000,1,0);
`ifdef JK_COUNTER_SAT_EN
    step(0,0,1,2'b10, 4'h0,4'h0,4'h0, 4'b0000,1,1);
`else
    step(0,0,1,2'b10, 4'h0,4'h0,4'h0, 4'b1111,0,1);
`endif
    // CE=0 holds, TC masked; S still acts
    step(0,0,1,2'b11, 4'h0,4'h0,4'b0110, 4'b0110,0,1);
    step(0,0,0,2'b01, 4'hF,4'hF,4'hF, 4'b0110,0,1);
    step(0,0,0,2'b01, 4'hF,4'hF,4'hF, 4'b0110,0,1);
    step(0,0,0,2'b01, 4'hF,4'hF,4'hF, 4'b0110,0,1);
    step(0,1,0,2'b01, 4'h0,4'h0,4'h0, 4'b1111,0,0);
    // R beats load, then load proceeds
    step(1,0,1,2'b11, 4'h0,4'h0,4'b1011, 4'b0000,0,0);
    step(0,0,1,2'b11, 4'h0,4'h0,4'b1011, 4'b1011,0,0);
    // R at the wrap edge: OVF stays 0
    step(0,0,1,2'b11, 4'h0,4'h0,4'b1111, 4'b1111,0,0);
    step(1,0,1,2'b01, 4'h0,4'h0,4'h0, 4'b0000,0,0);
    // TC is 0 in JK mode even at all ones
    step(0,0,1,2'b11, 4'h0,4'h0,4'b1111, 4'b1111,0,0);
    step(0,0,1,2'b00, 4'h0,4'h0,4'h0, 4'b1111,0,0);
    // mode change mid-count: up then down from 0111
    step(0,0,1,2'b11, 4'h0,4'h0,4'b0111, 4'b0111,0,0);
    step(0,0,1,2'b01, 4'h0,4'h0,4'h0, 4'b1000,0,0);
    step(0,0,1,2'b10, 4'h0,4'h0,4'h0, 4'b0111,0,0);

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge CLK);
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations never compared, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
